mem_bist_ctrl: RTL and testbench

Parametrised memory built-in self-test controller. It drives a single-port synchronous-write RAM through a four-pass march test and compares read-back data against a selectable pattern. It reports sticky finish/error, a saturating error count and the first failing address/data. It is the generalised successor of the fixed 32K x 16 tester: configurable width, depth, read latency and data pattern.

---
 rtl/mem_bist_pkg.sv | 37 +++
 rtl/mem_bist_cmp.sv | 91 +++++++++
 rtl/mem_bist_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and pattern generator for the march-test memory BIST controller.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] PAT_ZERO = 2'd0;
  localparam logic [1:0] PAT_CHK  = 2'd1;
  localparam logic [1:0] PAT_ADR  = 2'd2;
  localparam logic [1:0] PAT_SEED = 2'd3;

  localparam logic [1:0] PASS_WR_UP = 2'd0;
  localparam logic [1:0] PASS_RD_UP = 2'd1;
  localparam logic [1:0] PASS_WR_DN = 2'd2;
  localparam logic [1:0] PASS_RD_DN = 2'd3;

  // Built at 64 bits and truncated by the caller; an even DATA_W keeps the
  // checkerboard phase (LSB = 1 on even addresses) width-independent.
  function automatic logic [63:0] pat_word(input logic [1:0]  pattern,
                                           input logic [63:0] seed,
                                           input logic [63:0] addr,
                                           input logic        invert);
    logic [63:0] w;
    case (pattern)
      PAT_ZERO: w = '0;
      PAT_CHK:  w = addr[0] ? {32{2'b10}} : {32{2'b01}};
      PAT_ADR:  w = addr;
      default:  w = seed ^ addr;
    endcase
    return invert ? ~w : w;
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-latency delay line for expected data/address, comparator, saturating
// error counter and first-failure capture. MEM_BIST_STOP_ON_ERR_EN: count only the first mismatch.
module mem_bist_cmp
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_adrs,
  input  logic [DATA_W-1:0] in_exp,
  input  logic [DATA_W-1:0] rdata,
  output logic              error,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_adrs,
  output logic [DATA_W-1:0] err_data,
  output logic              halt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              cur_vld;
  logic [ADDR_W-1:0] cur_adrs;
  logic [DATA_W-1:0] cur_exp;
  logic              mismatch;
  logic              cnt_en;

  generate
    if (RD_LAT == 0) begin : g_comb
      assign cur_vld  = in_vld;
      assign cur_adrs = in_adrs;
      assign cur_exp  = in_exp;
    end else begin : g_dly
      logic [RD_LAT-1:0]             vld_pipe;
      logic [RD_LAT-1:0][ADDR_W-1:0] adr_pipe;
      logic [RD_LAT-1:0][DATA_W-1:0] exp_pipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[0] <= in_vld;
          for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
        adr_pipe[0] <= in_adrs;
        exp_pipe[0] <= in_exp;
        for (int i = 1; i < RD_LAT; i++) begin
          adr_pipe[i] <= adr_pipe[i-1];
          exp_pipe[i] <= exp_pipe[i-1];
        end
      end

      assign cur_vld  = vld_pipe[RD_LAT-1];
      assign cur_adrs = adr_pipe[RD_LAT-1];
      assign cur_exp  = exp_pipe[RD_LAT-1];
    end
  endgenerate

  assign mismatch = cur_vld && (rdata != cur_exp);

`ifdef MEM_BIST_STOP_ON_ERR_EN
  // Anything still in flight after the first failure is flushed uncounted.
  assign cnt_en = mismatch && !error;
  assign halt   = mismatch || error;
`else
  assign cnt_en = mismatch;
  assign halt   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      error     <= 1'b0;
      err_count <= '0;
      err_adrs  <= '0;
      err_data  <= '0;
    end else if (cnt_en) begin
      error <= 1'b1;
      if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
      if (!error) begin
        err_adrs <= cur_adrs;
        err_data <= rdata;
      end
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Four-pass march BIST controller for a single-port RAM with configurable read latency.
// Optional MEM_BIST_STOP_ON_ERR_EN: end the test after the first mismatch.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        pattern,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              finish,
  output logic              error,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_adrs,
  output logic [DATA_W-1:0] err_data,
  output logic [1:0]        pass,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [1:0]        DLAST    = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_e            state, state_n;
  logic [1:0]        pass_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [1:0]        dcnt, dcnt_n;
  logic              launch, launch_n;
  logic              clr;
  logic [1:0]        pat_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] word;
  logic              rd_vld;
  logic              halt;
  logic              last_adr;

  assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
  assign mem_adrs = addr;
  assign mem_we   = (state == ST_RUN) && !pass[0];
  assign rd_vld   = (state == ST_RUN) &&  pass[0];
  assign last_adr = pass[1] ? (addr == '0) : (addr == ADDR_MAX);

  // Passes 2/3 use the inverted pattern.
  assign word      = DATA_W'(pat_word(pat_q, 64'(seed_q), 64'(addr), pass[1]));
  assign mem_wdata = mem_we ? word : '0;

  always_comb begin
    state_n  = state;
    pass_n   = pass;
    addr_n   = addr;
    dcnt_n   = dcnt;
    launch_n = 1'b0;
    clr      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_n = ST_IDLE;
        if (launch) begin
          state_n = ST_RUN;
          pass_n  = PASS_WR_UP;
          addr_n  = '0;
        end else if (start) begin
          clr      = 1'b1;
          launch_n = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_n = (RD_LAT == 0) ? ST_DONE : ST_DRAIN;
          dcnt_n  = '0;
        end else if (last_adr) begin
          case (pass)
            PASS_WR_UP: begin
              pass_n = PASS_RD_UP;
              addr_n = '0;
            end
            PASS_RD_UP: begin
              if (RD_LAT == 0) begin
                pass_n = PASS_WR_DN;
                addr_n = ADDR_MAX;
              end else begin
                state_n = ST_DRAIN;
                dcnt_n  = '0;
              end
            end
            PASS_WR_DN: begin
              pass_n = PASS_RD_DN;
              addr_n = ADDR_MAX;
            end
            default: begin
              if (RD_LAT == 0) begin
                state_n = ST_DONE;
              end else begin
                state_n = ST_DRAIN;
                dcnt_n  = '0;
              end
            end
          endcase
        end else begin
          addr_n = pass[1] ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (dcnt == DLAST) begin
          if (halt || (pass == PASS_RD_DN)) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_RUN;
            pass_n  = PASS_WR_DN;
            addr_n  = ADDR_MAX;
          end
        end else begin
          dcnt_n = dcnt + 2'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pass   <= '0;
      addr   <= '0;
      dcnt   <= '0;
      launch <= 1'b0;
      pat_q  <= '0;
      seed_q <= '0;
      finish <= 1'b0;
    end else begin
      state  <= state_n;
      pass   <= pass_n;
      addr   <= addr_n;
      dcnt   <= dcnt_n;
      launch <= launch_n;
      if (clr) begin
        pat_q  <= pattern;
        seed_q <= seed;
      end
      if (clr)                    finish <= 1'b0;
      else if (state == ST_DONE)  finish <= 1'b1;
    end
  end

  mem_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT),
    .CNT_W (CNT_W)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_vld   (rd_vld),
    .in_adrs  (addr),
    .in_exp   (word),
    .rdata    (mem_rdata),
    .error    (error),
    .err_count(err_count),
    .err_adrs (err_adrs),
    .err_data (err_data),
    .halt     (halt)
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl: 16x8 RAM models at read latency 0 and 2.
module tb_mem_bist_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

`ifdef MEM_BIST_STOP_ON_ERR_EN
  localparam int N3A = 28, N3B = 32, W3 = 16, N4 = 20, C4 = 1, W4 = 16;
`else
  localparam int N3A = 66, N3B = 70, W3 = 32, N4 = 66, C4 = 15, W4 = 32;
`endif

  typedef struct {
    int t0; int ncyc; int err; int cnt; int adr; int dat; int nwe;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  exp_t q0[$], q2[$];

  logic          rst0, start0, busy0, fin0, err0, mwe0;
  logic [1:0]    pat0, pass0;
  logic [DW-1:0] seed0, edat0, mwd0, mrd0;
  logic [3:0]    cnt0;
  logic [AW-1:0] eadr0, madr0;
  logic          rst2, start2, busy2, fin2, err2, mwe2;
  logic [1:0]    pat2, pass2;
  logic [DW-1:0] seed2, edat2, mwd2, mrd2, r1;
  logic [7:0]    cnt2;
  logic [AW-1:0] eadr2, madr2;
  int fault0 = 0, fault2 = 0;

  mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .pattern(pat0), .seed(seed0),
    .busy(busy0), .finish(fin0), .error(err0), .err_count(cnt0), .err_adrs(eadr0),
    .err_data(edat0), .pass(pass0), .mem_adrs(madr0), .mem_wdata(mwd0),
    .mem_we(mwe0), .mem_rdata(mrd0));

  mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst2), .start(start2), .pattern(pat2), .seed(seed2),
    .busy(busy2), .finish(fin2), .error(err2), .err_count(cnt2), .err_adrs(eadr2),
    .err_data(edat2), .pass(pass2), .mem_adrs(madr2), .mem_wdata(mwd2),
    .mem_we(mwe2), .mem_rdata(mrd2));

  // fault 1: bit 3 of address 9 stuck at 1; fault 2: writes lost, RAM reads 0
  function automatic logic [7:0] rd_fault(input int f, input logic [7:0] d, input logic [3:0] a);
    if (f == 2) return 8'h00;
    if (f == 1 && a == 4'h9) return d | 8'h08;
    return d;
  endfunction

  function automatic logic [7:0] tb_pat(input logic [1:0] p, input logic [7:0] s,
                                        input logic [3:0] a, input logic inv);
    logic [7:0] w;
    case (p)
      2'd0: w = 8'h00;
      2'd1: w = a[0] ? 8'hAA : 8'h55;
      2'd2: w = {4'h0, a};
      default: w = s ^ {4'h0, a};
    endcase
    return inv ? ~w : w;
  endfunction

  logic [DW-1:0] ram0 [16];
  logic [DW-1:0] ram2 [16];
  always @(posedge clk) if (mwe0) ram0[madr0] <= mwd0;
  assign mrd0 = rd_fault(fault0, ram0[madr0], madr0);
  always @(posedge clk) begin
    if (mwe2) ram2[madr2] <= mwd2;
    r1   <= rd_fault(fault2, ram2[madr2], madr2);
    mrd2 <= r1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic finish_cmp(input string tag, input exp_t e, input int n, input logic err,
                            input int cnt, input int adr, input int dat,
                            input int nwe, input int nbad, input int nwd);
    chk({tag, "_cycles"}, 64'(n), 64'(e.ncyc));
    chk({tag, "_error"}, 64'(err), 64'(e.err));
    chk({tag, "_err_count"}, 64'(cnt), 64'(e.cnt));
    chk({tag, "_err_adrs"}, 64'(adr), 64'(e.adr));
    chk({tag, "_err_data"}, 64'(dat), 64'(e.dat));
    chk({tag, "_we_cycles"}, 64'(nwe), 64'(e.nwe));
    chk({tag, "_we_outside_write"}, 64'(nbad), 64'd0);
    chk({tag, "_wdata_bad"}, 64'(nwd), 64'd0);
  endtask

  initial begin : mon0
    logic fp, bp;
    int nwe, nbad, nwd;
    exp_t e;
    fp = 1'b0; bp = 1'b0; nwe = 0; nbad = 0; nwd = 0;
    forever begin
      @(negedge clk);
      if (busy0 && !bp) begin nwe = 0; nbad = 0; nwd = 0; end
      if (mwe0 === 1'b1) begin
        nwe++;
        if (!busy0 || pass0[0]) nbad++;
        if (mwd0 !== tb_pat(pat0, seed0, madr0, pass0[1])) nwd++;
      end
      if (fin0 && !fp) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL u0_unexpected_finish got 1 want 0");
        end else begin
          e = q0.pop_front();
          finish_cmp("u0", e, cyc - e.t0, err0, int'(cnt0), int'(eadr0), int'(edat0), nwe, nbad, nwd);
        end
      end
      fp = fin0; bp = busy0;
    end
  end

  initial begin : mon2
    logic fp, bp;
    int nwe, nbad, nwd;
    exp_t e;
    fp = 1'b0; bp = 1'b0; nwe = 0; nbad = 0; nwd = 0;
    forever begin
      @(negedge clk);
      if (busy2 && !bp) begin nwe = 0; nbad = 0; nwd = 0; end
      if (mwe2 === 1'b1) begin
        nwe++;
        if (!busy2 || pass2[0]) nbad++;
        if (mwd2 !== tb_pat(pat2, seed2, madr2, pass2[1])) nwd++;
      end
      if (fin2 && !fp) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL u2_unexpected_finish got 1 want 0");
        end else begin
          e = q2.pop_front();
          finish_cmp("u2", e, cyc - e.t0, err2, int'(cnt2), int'(eadr2), int'(edat2), nwe, nbad, nwd);
        end
      end
      fp = fin2; bp = busy2;
    end
  end

  task automatic go(input int id, input logic [1:0] p, input logic [7:0] s, input int f,
                    input int ncyc, input int err, input int cnt, input int adr,
                    input int dat, input int nwe, input bit poke);
    exp_t e;
    int n;
    @(negedge clk);
    if (id == 0) begin fault0 = f; pat0 = p; seed0 = s; start0 = 1'b1; end
    else         begin fault2 = f; pat2 = p; seed2 = s; start2 = 1'b1; end
    @(negedge clk);
    start0 = 1'b0; start2 = 1'b0;
    e.t0 = cyc; e.ncyc = ncyc; e.err = err; e.cnt = cnt; e.adr = adr; e.dat = dat; e.nwe = nwe;
    if (id == 0) q0.push_back(e); else q2.push_back(e);
    n = 0;
    while (((id == 0) ? q0.size() : q2.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (poke) start0 = (n == 10 || n == 40);
    end
    start0 = 1'b0;
    if (((id == 0) ? q0.size() : q2.size()) != 0) begin
      checks++; errors++;
      $display("FAIL u%0d_timeout got no finish want finish within 400 cycles", id);
      if (id == 0) q0.delete(); else q2.delete();
    end
  endtask

  task automatic check_rst0(input string tag);
    chk({tag, "_busy"}, 64'(busy0), 64'd0);
    chk({tag, "_finish"}, 64'(fin0), 64'd0);
    chk({tag, "_error"}, 64'(err0), 64'd0);
    chk({tag, "_err_count"}, 64'(cnt0), 64'd0);
    chk({tag, "_err_adrs"}, 64'(eadr0), 64'd0);
    chk({tag, "_err_data"}, 64'(edat0), 64'd0);
    chk({tag, "_pass"}, 64'(pass0), 64'd0);
    chk({tag, "_mem_adrs"}, 64'(madr0), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mwd0), 64'd0);
    chk({tag, "_mem_we"}, 64'(mwe0), 64'd0);
  endtask

  initial begin : stim
    int n;
    rst0 = 1'b1; rst2 = 1'b1; start0 = 1'b0; start2 = 1'b0;
    pat0 = 2'd0; pat2 = 2'd0; seed0 = '0; seed2 = '0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst2 = 1'b0;
    check_rst0("reset");

    go(0, 2'd1, 8'h00, 0, 66, 0, 0, 0, 0, 32, 1'b0);          // checkerboard, RD_LAT 0
    go(2, 2'd1, 8'h00, 0, 70, 0, 0, 0, 0, 32, 1'b0);          // checkerboard, RD_LAT 2
    go(0, 2'd0, 8'h00, 1, N3A, 1, 1, 9, 8'h08, W3, 1'b0);     // stuck bit at 0x9
    go(2, 2'd0, 8'h00, 1, N3B, 1, 1, 9, 8'h08, W3, 1'b0);
    go(0, 2'd2, 8'h00, 2, N4, 1, C4, 1, 8'h00, W4, 1'b0);     // writes lost, saturation
    go(2, 2'd3, 8'hA5, 0, 70, 0, 0, 0, 0, 32, 1'b0);          // seed pattern
    go(2, 2'd2, 8'h00, 0, 70, 0, 0, 0, 0, 32, 1'b0);          // address pattern

    // Abort a run in pass 2 with reset; no finish is expected from it.
    @(negedge clk);
    fault0 = 0; pat0 = 2'd3; seed0 = 8'h3C; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (pass0 != 2'd2 && n < 200) begin @(negedge clk); n++; end
    chk("abort_reached_pass2", 64'(pass0), 64'd2);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check_rst0("abort");
    go(0, 2'd2, 8'h00, 0, 66, 0, 0, 0, 0, 32, 1'b1);          // start pokes while busy

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
